// File: rtl/fifo_thresh_buffer.sv
// fifo_thresh_buffer: single-clock data FIFO with almost-empty/almost-full
// thresholds, upstream backpressure and overflow/underflow reporting.
// Registered read data with 1-cycle latency; no fall-through when empty.
// Optional build macro: FIFO_ERR_STICKY_EN (error latches until reset).
module fifo_thresh_buffer #(
   parameter int DATA_WIDTH = 6,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  pop,
   input  logic [ADDR_WIDTH-1:0] limit_low,
   input  logic [ADDR_WIDTH-1:0] limit_high,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_empty,
   output logic                  almost_full,
   output logic                  pause,
   output logic                  error
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic [DATA_WIDTH-1:0] r_data_out;
   logic                  r_valid_out;
   logic                  r_error;

   logic                  w_empty;
   logic                  w_full;
   logic                  w_rd_acc;
   logic                  w_wr_acc;
   logic                  w_err_evt;
   logic [ADDR_WIDTH:0]   w_hi_lim;

   // Status and acceptance decode from registered count and live limits
   always_comb begin
      w_empty   = (r_count == '0);
      w_full    = (r_count == LP_DEPTH);
      w_rd_acc  = pop && !w_empty;
      // a pop on a full FIFO frees the slot the push needs in the same edge
      w_wr_acc  = push && (!w_full || w_rd_acc);
      w_err_evt = (push && w_full && !pop) || (pop && w_empty);
      // limit_high of 0 cannot be reached meaningfully, so it means DEPTH
      w_hi_lim  = (limit_high == '0) ? LP_DEPTH : {1'b0, limit_high};
   end

   // Storage: no reset on contents, but writes are blocked while in reset
   always_ff @(posedge clk) begin
      if (reset && w_wr_acc)
         r_mem[r_wr_ptr] <= data_in;
   end

   // Pointers, occupancy, registered read port and error reporting
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_data_out  <= '0;
         r_valid_out <= 1'b0;
         r_error     <= 1'b0;
      end else begin
         r_valid_out <= w_rd_acc;
         if (w_rd_acc) begin
            r_data_out <= r_mem[r_rd_ptr];
            r_rd_ptr   <= r_rd_ptr + 1'b1;
         end
         if (w_wr_acc)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_wr_acc && !w_rd_acc)
            r_count <= r_count + 1'b1;
         else if (w_rd_acc && !w_wr_acc)
            r_count <= r_count - 1'b1;
`ifdef FIFO_ERR_STICKY_EN
         r_error <= r_error | w_err_evt;
`else
         r_error <= w_err_evt;
`endif
      end
   end

   assign data_out     = r_data_out;
   assign valid_out    = r_valid_out;
   assign empty        = w_empty;
   assign full         = w_full;
   assign almost_empty = (r_count <= {1'b0, limit_low});
   assign almost_full  = (r_count >= w_hi_lim);
   assign pause        = almost_full;
   assign error        = r_error;

endmodule

// File: tb/tb_fifo_thresh_buffer.sv
// tb_fifo_thresh_buffer: directed test-plan steps followed by randomized
// traffic, all checked against a queue-based reference model.
module tb_fifo_thresh_buffer;

   localparam int DW    = 6;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          push = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic          pop = 1'b0;
   logic [AW-1:0] limit_low = 3'd2;
   logic [AW-1:0] limit_high = 3'd6;
   logic [DW-1:0] data_out;
   logic          valid_out, empty, full, almost_empty, almost_full, pause, error;

   int checks = 0;
   int failures = 0;

   // reference model state
   logic [DW-1:0] q[$];
   logic [DW-1:0] exp_dout = '0;
   logic          exp_valid = 1'b0;
   logic          exp_err = 1'b0;

   fifo_thresh_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
      .limit_low(limit_low), .limit_high(limit_high), .data_out(data_out),
      .valid_out(valid_out), .empty(empty), .full(full),
      .almost_empty(almost_empty), .almost_full(almost_full),
      .pause(pause), .error(error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // compare every output against the model, flags computed from occupancy
   task automatic check_all(input string tag);
      int n;
      int hi;
      n  = q.size();
      hi = (limit_high == 0) ? DEPTH : int'(limit_high);
      chk({tag, ".data_out"},  32'(data_out), 32'(exp_dout));
      chk({tag, ".valid_out"}, 32'(valid_out), 32'(exp_valid));
      chk({tag, ".empty"},     32'(empty), 32'(n == 0));
      chk({tag, ".full"},      32'(full), 32'(n == DEPTH));
      chk({tag, ".aempty"},    32'(almost_empty), 32'(n <= int'(limit_low)));
      chk({tag, ".afull"},     32'(almost_full), 32'(n >= hi));
      chk({tag, ".pause"},     32'(pause), 32'(n >= hi));
      chk({tag, ".error"},     32'(error), 32'(exp_err));
   endtask

   // one clock with the given request; model advances at the edge
   task automatic cyc(input logic p, input logic [DW-1:0] d, input logic o, input string tag);
      bit is_full, is_empty, rd, wr, ev;
      push = p; data_in = d; pop = o;
      is_full  = (q.size() == DEPTH);
      is_empty = (q.size() == 0);
      rd = o && !is_empty;
      wr = p && (!is_full || rd);
      ev = (p && is_full && !o) || (o && is_empty);
      @(posedge clk); #1;
      if (rd) exp_dout = q.pop_front();
      exp_valid = rd;
      if (wr) q.push_back(d);
`ifdef FIFO_ERR_STICKY_EN
      exp_err = exp_err | ev;
`else
      exp_err = ev;
`endif
      check_all(tag);
   endtask

   // one reset clock; a push is presented to confirm it is discarded
   task automatic do_reset(input logic p, input string tag);
      reset = 1'b0; push = p; data_in = 6'h2C; pop = 1'b0;
      @(posedge clk); #1;
      q.delete();
      exp_dout = '0; exp_valid = 1'b0; exp_err = 1'b0;
      check_all(tag);
      reset = 1'b1;
   endtask

   initial begin
      // reset 2 cycles, single word round trip
      reset = 1'b0;
      @(posedge clk); #1;
      do_reset(1'b0, "rst1");
      reset = 1'b0;
      do_reset(1'b0, "rst2");
      cyc(1'b1, 6'h15, 1'b0, "push15");
      cyc(1'b0, 6'h00, 1'b1, "pop15");
      cyc(1'b0, 6'h00, 1'b0, "idle15");

      // fill 8, watch thresholds, drain in order
      limit_low = 3'd2; limit_high = 3'd6;
      for (int i = 1; i <= 8; i++) cyc(1'b1, 6'(i), 1'b0, "fill");
      for (int i = 0; i < 8; i++) cyc(1'b0, 6'h00, 1'b1, "drain");

      // overflow on full, then simultaneous push/pop on full
      for (int i = 0; i < 8; i++) cyc(1'b1, 6'(8'h20 + i), 1'b0, "fill2");
      limit_high = 3'd0;
      cyc(1'b0, 6'h00, 1'b0, "lim0");
      cyc(1'b1, 6'h3F, 1'b0, "ovf");
      cyc(1'b0, 6'h00, 1'b0, "ovf_after");
      cyc(1'b0, 6'h00, 1'b0, "ovf_after2");
      limit_high = 3'd6;
      cyc(1'b1, 6'h2A, 1'b1, "fullpp");
      for (int i = 0; i < 9; i++) cyc(1'b0, 6'h00, 1'b1, "drain2");

      // underflow with simultaneous push on empty
      cyc(1'b1, 6'h11, 1'b1, "emptypp");
      cyc(1'b0, 6'h00, 1'b1, "pop11");
      cyc(1'b0, 6'h00, 1'b0, "idle11");

      // reset mid-stream, then wrap and overflow
      for (int i = 0; i < 5; i++) cyc(1'b1, 6'(8'h30 + i), 1'b0, "pre_rst");
      do_reset(1'b1, "midrst");
      for (int i = 0; i < 10; i++) cyc(1'b1, 6'(8'h01 + i), 1'b0, "wrap");
      for (int i = 0; i < 9; i++) cyc(1'b0, 6'h00, 1'b1, "drain3");

      // randomized traffic with changing limits and rare resets
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            limit_low  = 3'($urandom_range(0, 7));
            limit_high = 3'($urandom_range(0, 7));
         end
         if ($urandom_range(0, 199) == 0)
            do_reset(1'($urandom_range(0, 1)), "rnd_rst");
         else
            cyc(1'($urandom_range(0, 1)), 6'($urandom), 1'($urandom_range(0, 1)), "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
